fifo_rd_burst_packer: RTL and testbench

FIFO_RD_BURST_PACKER -- requirements
Module: fifo_rd_burst_packer

---
 rtl/fifo_rd_burst_packer.sv | 142 ++++++++++++++
 tb/tb_fifo_rd_burst_packer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_burst_packer.sv
// Reads a non-show-ahead FIFO into a 2-entry skid buffer and frames the stream into BURST_LEN-word bursts.
// Optional partial-burst padding after an idle timeout: define FIFO_RD_BURST_PACKER_TIMEOUT_EN.
module fifo_rd_burst_packer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_q_i,
  input  logic                  fifo_empty_i,
  output logic [DATA_WIDTH-1:0] src_data_o,
  output logic                  src_valid_o,
  input  logic                  src_ready_i,
  output logic                  src_sof_o,
  output logic                  src_eof_o,
  output logic                  src_pad_o,
  output logic [15:0]           burst_cnt_o
);

  localparam int unsigned IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  if (BURST_LEN < 2 || BURST_LEN > 256 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("fifo_rd_burst_packer: illegal BURST_LEN or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
`ifdef FIFO_RD_BURST_PACKER_TIMEOUT_EN
    , S_PAD  = 2'd2
`endif
  } state_t;

  state_t                state_q, state_nxt;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic [CNT_W-1:0]      burst_cnt_q;

  logic       pad_mode, valid, xfer, pop, is_last, timeout_hit, rd_ok;
  logic [1:0] occ_after, fill;

  // Handshake and skid-buffer bookkeeping; a pop in this cycle frees a slot for a new read.
  assign valid     = (occ_q != 2'd0) || pad_mode;
  assign xfer      = valid && src_ready_i;
  assign pop       = xfer && !pad_mode;
  assign is_last   = (idx_q == IDX_LAST);
  assign occ_after = occ_q - {1'b0, pop};
  assign fill      = occ_after + {1'b0, inflight_q};
  assign rd_ok     = rst_n_i && !fifo_empty_i && !pad_mode && (occ_q < 2'd2) && (fill < 2'd2);

`ifdef FIFO_RD_BURST_PACKER_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_q;
  logic             idle_wait;

  assign pad_mode    = (state_q == S_PAD);
  assign idle_wait   = (state_q == S_ACTIVE) && (occ_q == 2'd0) && !inflight_q && fifo_empty_i;
  assign timeout_hit = idle_wait && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive starved cycles of an open burst.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       to_cnt_q <= '0;
    else if (idle_wait) to_cnt_q <= to_cnt_q + CNT_W'(1);
    else                to_cnt_q <= '0;
  end
`else
  assign pad_mode    = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (xfer && idx_q == '0) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (xfer && is_last) state_nxt = S_IDLE;
`ifdef FIFO_RD_BURST_PACKER_TIMEOUT_EN
        else if (timeout_hit) state_nxt = S_PAD;
`endif
      end
`ifdef FIFO_RD_BURST_PACKER_TIMEOUT_EN
      S_PAD:    if (xfer && is_last) state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_o   = 1'b0;
    src_valid_o = 1'b0;
    src_sof_o   = 1'b0;
    src_eof_o   = 1'b0;
    src_pad_o   = 1'b0;
    src_data_o  = '0;
    fifo_rd_o   = rd_ok;
    src_valid_o = valid;
    src_sof_o   = valid && (idx_q == '0);
    src_eof_o   = valid && is_last;
    src_pad_o   = pad_mode;
    src_data_o  = pad_mode ? '0 : skid_q[rd_ptr_q];
  end

  // Read data lands one cycle after the read strobe; the word index and burst count advance on transfers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      idx_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      occ_q      <= fill;
      inflight_q <= rd_ok;
      if (inflight_q) begin
        skid_q[wr_ptr_q] <= fifo_q_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (xfer) begin
        idx_q <= is_last ? '0 : idx_q + IDX_W'(1);
        if (is_last) burst_cnt_q <= burst_cnt_q + CNT_W'(1);
      end
    end
  end

  assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_fifo_rd_burst_packer.sv
// Directed bench for fifo_rd_burst_packer with a behavioural non-show-ahead FIFO in front of it.
module tb_fifo_rd_burst_packer;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        fifo_rd_o;
  logic [15:0] fifo_q_i = '0;
  logic        fifo_empty_i;
  logic [15:0] src_data_o;
  logic        src_valid_o;
  logic        src_ready_i = 1'b0;
  logic        src_sof_o, src_eof_o, src_pad_o;
  logic [15:0] burst_cnt_o;

  fifo_rd_burst_packer #(.DATA_WIDTH(16), .BURST_LEN(8), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .fifo_rd_o(fifo_rd_o), .fifo_q_i(fifo_q_i),
    .fifo_empty_i(fifo_empty_i), .src_data_o(src_data_o), .src_valid_o(src_valid_o),
    .src_ready_i(src_ready_i), .src_sof_o(src_sof_o), .src_eof_o(src_eof_o),
    .src_pad_o(src_pad_o), .burst_cnt_o(burst_cnt_o)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [128];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [15:0] pend [$];
  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_o) begin
      fifo_q_i <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  int tests = 0;
  int fails = 0;
  int cnum = 0;
  int rd_cnt = 0;
  int first_rd = -1;
  int first_vld = -1;
  logic [15:0] xd [$];
  logic        xs [$];
  logic        xe [$];
  logic        xp [$];
  int          xc [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_vec = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    pend.push_back(d);
  endtask

  task automatic clear();
    xd.delete(); xs.delete(); xe.delete(); xp.delete(); xc.delete();
    first_rd = -1;
    first_vld = -1;
  endtask

  // One clock: load pending FIFO words, drive ready, then sample outputs after the falling edge.
  task automatic cyc(input logic r);
    logic [31:0] vec;
    @(negedge clk);
    while (pend.size() > 0) begin
      mem[wr_ptr] = pend.pop_front();
      wr_ptr++;
    end
    src_ready_i = r;
    #1;
    cnum++;
    vec = {13'd0, src_sof_o, src_eof_o, src_pad_o, src_data_o};
    if (prev_stall) begin
      chk("hold_valid", 32'(src_valid_o), 32'd1);
      chk("hold_payload", vec, prev_vec);
    end
    if (fifo_rd_o) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cnum;
    end
    if (src_valid_o && first_vld < 0) first_vld = cnum;
    if (src_valid_o && src_ready_i) begin
      xd.push_back(src_data_o); xs.push_back(src_sof_o); xe.push_back(src_eof_o);
      xp.push_back(src_pad_o); xc.push_back(cnum);
    end
    prev_stall = src_valid_o && !src_ready_i;
    prev_vec = vec;
  endtask

  task automatic run_until(input int n, input int budget, input bit tog);
    logic r = 1'b1;
    int k = 0;
    while (xd.size() < n && k < budget) begin
      cyc(r);
      if (tog) r = ~r;
      k++;
    end
  endtask

  initial begin
    int rd0;
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(src_valid_o), 32'd0);
    chk("rst_sof", 32'(src_sof_o), 32'd0);
    chk("rst_eof", 32'(src_eof_o), 32'd0);
    chk("rst_pad", 32'(src_pad_o), 32'd0);
    chk("rst_data", 32'(src_data_o), 32'd0);
    chk("rst_rd", 32'(fifo_rd_o), 32'd0);
    chk("rst_cnt", 32'(burst_cnt_o), 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    cyc(1'b0);

    // One full burst with ready held high
    clear();
    for (int i = 0; i < 8; i++) push(16'(i + 1));
    run_until(8, 40, 1'b0);
    cyc(1'b0);
    chk("b1_count", 32'(xd.size()), 32'd8);
    for (int i = 0; i < xd.size(); i++) begin
      chk("b1_data", 32'(xd[i]), 32'(i + 1));
      chk("b1_sof", 32'(xs[i]), 32'(i == 0));
      chk("b1_eof", 32'(xe[i]), 32'(i == 7));
      chk("b1_pad", 32'(xp[i]), 32'd0);
    end
    if (xc.size() == 8) chk("b1_back_to_back", 32'(xc[7] - xc[0]), 32'd7);
    chk("b1_latency", 32'(first_vld - first_rd), 32'd2);
    chk("b1_burst_cnt", 32'(burst_cnt_o), 32'd1);

    // Two bursts with ready toggling every cycle
    clear();
    rd0 = rd_cnt;
    for (int i = 0; i < 16; i++) push(16'h0101 + 16'(i));
    run_until(16, 200, 1'b1);
    cyc(1'b0);
    chk("b2_count", 32'(xd.size()), 32'd16);
    for (int i = 0; i < xd.size(); i++) begin
      chk("b2_data", 32'(xd[i]), 32'h0101 + 32'(i));
      chk("b2_sof", 32'(xs[i]), 32'(i % 8 == 0));
      chk("b2_eof", 32'(xe[i]), 32'(i % 8 == 7));
    end
    chk("b2_reads", 32'(rd_cnt - rd0), 32'd16);
    chk("b2_burst_cnt", 32'(burst_cnt_o), 32'd3);

    // Partial burst followed by a long FIFO drought
    clear();
    for (int i = 0; i < 3; i++) push(16'h0A01 + 16'(i));
`ifdef FIFO_RD_BURST_PACKER_TIMEOUT_EN
    run_until(8, 200, 1'b0);
    cyc(1'b0);
    chk("to_count", 32'(xd.size()), 32'd8);
    for (int i = 0; i < xd.size(); i++) begin
      chk("to_data", 32'(xd[i]), (i < 3) ? 32'h0A01 + 32'(i) : 32'd0);
      chk("to_pad", 32'(xp[i]), 32'(i >= 3));
      chk("to_sof", 32'(xs[i]), 32'(i == 0));
      chk("to_eof", 32'(xe[i]), 32'(i == 7));
    end
    chk("to_burst_cnt", 32'(burst_cnt_o), 32'd4);
`else
    repeat (1000) cyc(1'b1);
    chk("wait_count", 32'(xd.size()), 32'd3);
    chk("wait_valid_low", 32'(src_valid_o), 32'd0);
    chk("wait_pad", 32'(src_pad_o), 32'd0);
    chk("wait_burst_cnt", 32'(burst_cnt_o), 32'd3);
    clear();
    for (int i = 3; i < 8; i++) push(16'h0A01 + 16'(i));
    run_until(5, 40, 1'b0);
    cyc(1'b0);
    chk("fill_count", 32'(xd.size()), 32'd5);
    for (int i = 0; i < xd.size(); i++) begin
      chk("fill_data", 32'(xd[i]), 32'h0A04 + 32'(i));
      chk("fill_sof", 32'(xs[i]), 32'd0);
      chk("fill_eof", 32'(xe[i]), 32'(i == 4));
      chk("fill_pad", 32'(xp[i]), 32'd0);
    end
    chk("fill_burst_cnt", 32'(burst_cnt_o), 32'd4);
`endif

    // Single word: FIFO empties right after its read, no extra read issued
    clear();
    rd0 = rd_cnt;
    push(16'h0B01);
    repeat (10) cyc(1'b1);
    chk("last_reads", 32'(rd_cnt - rd0), 32'd1);
    chk("last_count", 32'(xd.size()), 32'd1);
    if (xd.size() == 1) begin
      chk("last_data", 32'(xd[0]), 32'h0B01);
      chk("last_sof", 32'(xs[0]), 32'd1);
    end
    chk("last_valid_low", 32'(src_valid_o), 32'd0);
    clear();
    for (int i = 1; i < 8; i++) push(16'h0B01 + 16'(i));
    run_until(7, 40, 1'b0);
    cyc(1'b0);
    chk("last_fill_count", 32'(xd.size()), 32'd7);
    if (xd.size() == 7) begin
      chk("last_fill_data", 32'(xd[6]), 32'h0B08);
      chk("last_fill_eof", 32'(xe[6]), 32'd1);
    end
    chk("last_burst_cnt", 32'(burst_cnt_o), 32'd5);

    // Asynchronous reset after the 5th transfer of a burst
    clear();
    for (int i = 0; i < 8; i++) push(16'h0C01 + 16'(i));
    run_until(5, 40, 1'b0);
    chk("mid_count", 32'(xd.size()), 32'd5);
    @(posedge clk);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 32'(src_valid_o), 32'd0);
    chk("arst_sof", 32'(src_sof_o), 32'd0);
    chk("arst_eof", 32'(src_eof_o), 32'd0);
    chk("arst_data", 32'(src_data_o), 32'd0);
    chk("arst_rd", 32'(fifo_rd_o), 32'd0);
    chk("arst_cnt", 32'(burst_cnt_o), 32'd0);
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    clear();
    run_until(1, 40, 1'b0);
    cyc(1'b0);
    chk("post_rst_count", 32'(xd.size()), 32'd1);
    if (xs.size() >= 1) chk("post_rst_sof", 32'(xs[0]), 32'd1);
    chk("post_rst_cnt", 32'(burst_cnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
